eth_nios_v2_eth_ctrl_pio: RTL

- Avalon-MM output PIO that drives Ethernet PHY/MAC control lines (reset, mode straps, strobes) from the Nios II.
- It is the output-direction counterpart of the Ethernet IRQ input PIO and sits on the same Avalon-MM slave interconnect.
- Provides a static output level plus a hardware-timed one-shot pulse on selected bits, so firmware can issue exact-width control pulses without busy-waiting.
- Reports pulse completion through sticky status bits and an optional interrupt.

---
 rtl/eth_nios_v2_eth_ctrl_pio_if.sv | 18 +
 rtl/eth_nios_v2_eth_ctrl_pio.sv | 121 ++++++++++++
 2 files changed

// File: rtl/eth_nios_v2_eth_ctrl_pio_if.sv
// Avalon-MM slave bus bundle for the Ethernet control output PIO.
interface eth_nios_v2_eth_ctrl_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/eth_nios_v2_eth_ctrl_pio.sv
// Ethernet control output PIO: static level plus a hardware-timed one-shot pulse.
// Optional macro ETH_CTRL_PIO_DONE_IRQ_EN drives irq from the sticky done flag.
module eth_nios_v2_eth_ctrl_pio #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_RST = 100
) (
  input  logic                     clk,
  input  logic                     reset_n,
  eth_nios_v2_eth_ctrl_pio_if.slave bus,
  output logic [WIDTH-1:0]         out_port,
  output logic                     irq
);

  typedef enum logic {IDLE, PULSE} state_t;

  localparam logic [CNT_W-1:0] LEN_INIT = CNT_W'(LEN_RST);
`ifdef ETH_CTRL_PIO_DONE_IRQ_EN
  localparam logic IRQ_PRESENT = 1'b1;
`else
  localparam logic IRQ_PRESENT = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_en;
  logic               pulse_wr;
  logic               status_wr;

  always_comb begin
    wr_en     = bus.chipselect & ~bus.write_n;
    pulse_wr  = wr_en && (bus.address == 2'd1);
    status_wr = wr_en && (bus.address == 2'd3);

    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovr_d   = ovr_q;

    if (wr_en && (bus.address == 2'd0)) data_d = bus.writedata[WIDTH-1:0];
    if (wr_en && (bus.address == 2'd2)) len_d  = bus.writedata[CNT_W-1:0];
    if (status_wr) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end

    // Flag sets are evaluated after the STATUS clear so a same-edge set wins.
    case (state_q)
      IDLE: begin
        if (pulse_wr && (|bus.writedata[WIDTH-1:0])) begin
          state_d = PULSE;
          mask_d  = bus.writedata[WIDTH-1:0];
          cnt_d   = (len_q == '0) ? '0 : len_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (pulse_wr) ovr_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    out_d = data_d ^ ((state_d == PULSE) ? mask_d : '0);

    rdata_d = '0;
    case (bus.address)
      2'd0: rdata_d[WIDTH-1:0] = data_q;
      2'd1: rdata_d[WIDTH-1:0] = mask_q;
      2'd2: rdata_d[CNT_W-1:0] = len_q;
      2'd3: rdata_d[3:0]       = {IRQ_PRESENT, ovr_q, done_q, state_q == PULSE};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      out_q   <= '0;
      len_q   <= LEN_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

  assign out_port     = out_q;
  assign bus.readdata = rdata_q;

`ifdef ETH_CTRL_PIO_DONE_IRQ_EN
  assign irq = done_q;
`else
  assign irq = 1'b0;
`endif

endmodule
